// File: rtl/kernel_bram_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// kernel_bram_pingpong_ctrl
//
// Double-buffered kernel loader. An AXI-Stream slave fills one BRAM bank with
// one kernel of channel_size words while the convolution datapath reads the
// other bank word by word. The BRAM is simple dual-port, depth 2*2^ADDR_W:
// port A writes at {fill_bank, wptr}, port B reads at {read_bank, rd_ptr}.
//
// Ports
//   clk, Reset        clock; synchronous active-low reset
//   channel_size      words per kernel (1..2^ADDR_W), sampled at load start
//   load_req          level request to load one kernel into the fill bank
//   rd_next           advance the read pointer by one word
//   s_axis_*          AXI-Stream slave carrying kernel words
//   wr_en/addr/data   BRAM port A (registered, one cycle after the handshake)
//   rd_addr           BRAM port B address (registered)
//   rd_valid          read bank holds a complete kernel
//   last_channel      pulse: the accepted rd_next consumed the bank's last word
//   done_loading      pulse: a kernel load completed
//   bank_full         per-bank full flags
//   busy              load FSM not idle
//   tlast_err         sticky TLAST / word-count disagreement
// -----------------------------------------------------------------------------
module kernel_bram_pingpong_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [ADDR_W:0]   channel_size,
  input  logic              load_req,
  input  logic              rd_next,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   rd_addr,
  output logic              rd_valid,
  output logic              last_channel,
  output logic              done_loading,
  output logic [1:0]        bank_full,
  output logic              busy,
  output logic              tlast_err
);

  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} load_state_e;

  localparam logic [ADDR_W:0] SZ_ONE = (ADDR_W+1)'(1);

  load_state_e       state_q, state_d;
  logic              fill_bank_q, fill_bank_d;
  logic              read_bank_q, read_bank_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   chsz_q [2];
  logic [ADDR_W:0]   chsz_d [2];
  logic [1:0]        bank_full_q, bank_full_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              last_channel_q, last_channel_d;
  logic              tlast_err_q, tlast_err_d;

  logic handshake;
  logic wptr_last;
  logic rd_last;

  assign s_axis_tready = (state_q == L_LOAD);
  assign handshake     = s_axis_tvalid & s_axis_tready;
  // Compare against size-1 at full width so a 2^ADDR_W kernel ends at the
  // all-ones offset without overflowing the pointer.
  assign wptr_last     = ({1'b0, wptr_q}   == (chsz_q[fill_bank_q] - SZ_ONE));
  assign rd_last       = ({1'b0, rd_ptr_q} == (chsz_q[read_bank_q] - SZ_ONE));

  always_comb begin
    // NOTE: every next-state variable gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    state_d        = state_q;
    fill_bank_d    = fill_bank_q;
    read_bank_d    = read_bank_q;
    wptr_d         = wptr_q;
    rd_ptr_d       = rd_ptr_q;
    chsz_d         = chsz_q;
    bank_full_d    = bank_full_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    last_channel_d = 1'b0;
    tlast_err_d    = tlast_err_q;

    unique case (state_q)
      L_IDLE: begin
        // A full fill bank leaves load_req pending until the reader frees it.
        if (load_req && !bank_full_q[fill_bank_q]) begin
          state_d              = L_LOAD;
          chsz_d[fill_bank_q]  = channel_size;
          wptr_d               = '0;
        end
      end
      L_LOAD: begin
        if (handshake) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {fill_bank_q, wptr_q};
          wr_data_d = s_axis_tdata;
          // The word count alone ends a load; TLAST is only cross-checked.
          if (wptr_last) begin
            state_d = L_DONE;
            if (!s_axis_tlast) tlast_err_d = 1'b1;
          end else begin
            wptr_d = wptr_q + ADDR_W'(1);
            if (s_axis_tlast) tlast_err_d = 1'b1;
          end
        end
      end
      L_DONE: begin
        bank_full_d[fill_bank_q] = 1'b1;
        fill_bank_d              = ~fill_bank_q;
        state_d                  = L_IDLE;
      end
      default: state_d = L_IDLE;
    endcase

    // The bank being freed here is never the one L_DONE marks full, so the
    // two flag updates can share a cycle.
    if (rd_next && bank_full_q[read_bank_q]) begin
      if (rd_last) begin
        rd_ptr_d                 = '0;
        bank_full_d[read_bank_q] = 1'b0;
        read_bank_d              = ~read_bank_q;
        last_channel_d           = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
    end
  end

  // NOTE: Reset is sampled on clk only, matching the rest of this codebase;
  // the latched sizes are plain registers, so they are cleared with the rest.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      state_q        <= L_IDLE;
      fill_bank_q    <= 1'b0;
      read_bank_q    <= 1'b0;
      wptr_q         <= '0;
      rd_ptr_q       <= '0;
      chsz_q[0]      <= '0;
      chsz_q[1]      <= '0;
      bank_full_q    <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      last_channel_q <= 1'b0;
      tlast_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      fill_bank_q    <= fill_bank_d;
      read_bank_q    <= read_bank_d;
      wptr_q         <= wptr_d;
      rd_ptr_q       <= rd_ptr_d;
      chsz_q         <= chsz_d;
      bank_full_q    <= bank_full_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      last_channel_q <= last_channel_d;
      tlast_err_q    <= tlast_err_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign rd_addr      = {read_bank_q, rd_ptr_q};
  assign rd_valid     = bank_full_q[read_bank_q];
  assign last_channel = last_channel_q;
  assign done_loading = (state_q == L_DONE);
  assign bank_full    = bank_full_q;
  assign busy         = (state_q != L_IDLE);
  assign tlast_err    = tlast_err_q;

endmodule

// File: tb/tb_kernel_bram_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kernel_bram_pingpong_ctrl
//
// Randomised bench. A transaction-level reference keeps the two banks as
// {full, size} records, the loader as "words received so far" and the reader
// as "word index in the read bank", and predicts every output each cycle.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_kernel_bram_pingpong_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int BANK   = 1 << ADDR_W;
  localparam int CYCLES = 8000;

  logic              clk = 1'b0;
  logic              Reset;
  logic [ADDR_W:0]   channel_size;
  logic              load_req;
  logic              rd_next;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic              wr_en;
  logic [ADDR_W:0]   wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   rd_addr;
  logic              rd_valid;
  logic              last_channel;
  logic              done_loading;
  logic [1:0]        bank_full;
  logic              busy;
  logic              tlast_err;

  kernel_bram_pingpong_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .Reset(Reset), .channel_size(channel_size), .load_req(load_req),
    .rd_next(rd_next), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .last_channel(last_channel), .done_loading(done_loading), .bank_full(bank_full),
    .busy(busy), .tlast_err(tlast_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_loads  = 0;
  int n_kernels_read = 0;

  // Reference state, in transaction terms.
  bit       m_loading;     // stream words are being accepted
  bit       m_finishing;   // a load just completed; bank flagged next cycle
  int       m_cnt;         // words received in the current load
  int       m_fill;        // bank being filled
  int       m_read;        // bank being read
  bit       m_full [2];
  int       m_size [2];
  int       m_rptr;        // word index inside the read bank
  bit       m_err;
  bit       m_wr_en;
  int       m_wr_addr;
  bit [DATA_W-1:0] m_wr_data;
  bit       m_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    m_loading = 0; m_finishing = 0; m_cnt = 0; m_fill = 0; m_read = 0;
    m_full[0] = 0; m_full[1] = 0; m_size[0] = 0; m_size[1] = 0;
    m_rptr = 0; m_err = 0; m_wr_en = 0; m_wr_addr = 0; m_wr_data = '0; m_last = 0;
  endtask

  // Advance the reference across one rising edge using the inputs now driven.
  task automatic model_step();
    bit rd_ok, rd_fin;
    if (!Reset) begin
      model_clear();
      return;
    end
    // Reader decisions use the flags as they stood before this edge.
    rd_ok  = rd_next && m_full[m_read];
    rd_fin = rd_ok && (m_rptr == m_size[m_read] - 1);
    m_wr_en = 0;
    m_last  = 0;
    if (m_finishing) begin
      m_full[m_fill] = 1;
      m_fill        ^= 1;
      m_finishing    = 0;
      n_loads++;
    end else if (!m_loading) begin
      if (load_req && !m_full[m_fill]) begin
        m_loading      = 1;
        m_cnt          = 0;
        m_size[m_fill] = int'(channel_size);
      end
    end else if (s_axis_tvalid) begin
      m_wr_en   = 1;
      m_wr_addr = m_fill * BANK + m_cnt;
      m_wr_data = s_axis_tdata;
      m_cnt++;
      if (m_cnt == m_size[m_fill]) begin
        if (!s_axis_tlast) m_err = 1;
        m_loading   = 0;
        m_finishing = 1;
      end else if (s_axis_tlast) begin
        m_err = 1;
      end
    end
    if (rd_ok) begin
      if (rd_fin) begin
        m_rptr         = 0;
        m_full[m_read] = 0;
        m_read        ^= 1;
        m_last         = 1;
        n_kernels_read++;
      end else begin
        m_rptr++;
      end
    end
  endtask

  task automatic compare_all();
    check("tready",       64'(s_axis_tready), 64'(m_loading));
    check("wr_en",        64'(wr_en),         64'(m_wr_en));
    check("wr_addr",      64'(wr_addr),       64'(m_wr_addr));
    check("wr_data",      64'(wr_data),       64'(m_wr_data));
    check("rd_addr",      64'(rd_addr),       64'(m_read * BANK + m_rptr));
    check("rd_valid",     64'(rd_valid),      64'(m_full[m_read]));
    check("last_channel", 64'(last_channel),  64'(m_last));
    check("done_loading", 64'(done_loading),  64'(m_finishing));
    check("bank_full",    64'(bank_full),     64'({m_full[1], m_full[0]}));
    check("busy",         64'(busy),          64'(m_loading || m_finishing));
    check("tlast_err",    64'(tlast_err),     64'(m_err));
  endtask

  initial begin
    int phase, tv_pct, rd_pct, r;
    bit want_last;
    Reset = 1'b0; channel_size = '0; load_req = 1'b0; rd_next = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    model_clear();

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      compare_all();

      // Phases: streaming, gapped stream, stalled reader, fast reader.
      phase = (cyc / 2000) % 4;
      case (phase)
        0:       begin tv_pct = 100; rd_pct = 30; end
        1:       begin tv_pct = 50;  rd_pct = 40; end
        2:       begin tv_pct = 80;  rd_pct = 3;  end
        default: begin tv_pct = 70;  rd_pct = 80; end
      endcase

      Reset = !((cyc < 2) || ($urandom_range(0, 399) == 0));
      r = $urandom_range(0, 49);
      if (r == 0)      channel_size = (ADDR_W+1)'(BANK);
      else if (r < 8)  channel_size = (ADDR_W+1)'(1);
      else             channel_size = (ADDR_W+1)'($urandom_range(2, 6));
      load_req      = ($urandom_range(0, 99) < 70);
      rd_next       = ($urandom_range(0, 99) < rd_pct);
      s_axis_tvalid = ($urandom_range(0, 99) < tv_pct);
      s_axis_tdata  = $urandom;
      if (m_loading) begin
        want_last    = (m_cnt == m_size[m_fill] - 1);
        s_axis_tlast = want_last ^ ($urandom_range(0, 29) == 0);
      end else begin
        s_axis_tlast = 1'($urandom_range(0, 1));
      end

      model_step();
    end

    // The random run must actually have exercised both sides.
    check("loads_completed",  64'(n_loads > 20),        64'(1));
    check("kernels_consumed", 64'(n_kernels_read > 20), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kernel_bram_pingpong_ctrl.md
Name: kernel_bram_pingpong_ctrl

Overview:
- Parametrised, double-buffered successor to the single-kernel BRAM control unit.
- Streams one kernel of `channel_size` words per load from an AXI-Stream slave into one of two BRAM banks, while the convolution datapath reads the other bank word by word.
- Owns the write/read address counters, per-bank channel-size latching, bank ping-pong and TLAST consistency checking.
- Drives a simple dual-port BRAM of depth 2*2^ADDR_W: port A is write, port B is read.

Parameters:
DATA_W, 32, AXI-Stream data / BRAM word width
ADDR_W, 9, per-bank address width; maximum channel_size is 2^ADDR_W

Ports:
clk  in  1  clock
Reset  in  1  synchronous, active-low reset
channel_size  in  ADDR_W+1  words per kernel (1..2^ADDR_W); sampled at load start
load_req  in  1  level request to load one kernel into the fill bank
rd_next  in  1  advance read pointer by one word
s_axis_tdata  in  DATA_W  kernel word
s_axis_tvalid  in  1  stream valid
s_axis_tlast  in  1  expected on the last word of a kernel
s_axis_tready  out  1  stream ready
wr_en  out  1  BRAM port-A write enable
wr_addr  out  ADDR_W+1  {bank, offset}
wr_data  out  DATA_W  BRAM write data
rd_addr  out  ADDR_W+1  {read_bank, rd_ptr}; BRAM port B always enabled out of reset
rd_valid  out  1  read bank holds a complete kernel
last_channel  out  1  1-cycle pulse: the rd_next just accepted consumed the final word of the bank
done_loading  out  1  1-cycle pulse: a kernel load completed
bank_full  out  2  per-bank full flags
busy  out  1  load FSM not in L_IDLE
tlast_err  out  1  sticky TLAST mismatch flag

Behaviour:
- Reset: while Reset=0 at a clk edge, all outputs and state go to 0, including fill_bank, read_bank, pointers and latched sizes. A reset mid-load discards the partial bank; the bank stays not-full.
- Load FSM states: L_IDLE, L_LOAD, L_DONE.
- L_IDLE -> L_LOAD when load_req=1 and bank_full[fill_bank]=0.
  - On that edge, latch chsz[fill_bank] <= channel_size and clear wptr.
  - If the fill bank is full, wait in L_IDLE; load_req is not consumed.
- L_LOAD:
  - s_axis_tready=1, combinationally from state.
  - Each handshake (tvalid & tready) registers wr_en=1, wr_addr={fill_bank,wptr}, wr_data=tdata, so the write appears one cycle after the handshake. wr_en=0 otherwise.
  - Handshake with wptr==chsz-1 -> L_DONE. Otherwise wptr++.
  - tvalid low: stay in L_LOAD, no write.
- L_DONE (one cycle):
  - done_loading=1, bank_full[fill_bank]<=1, fill_bank toggles.
  - Next state is L_IDLE.
- TLAST check: tlast_err<=1 if tlast=1 on a handshake with wptr!=chsz-1, or tlast=0 on the final handshake.
  - The load length is always count-authoritative; TLAST never ends or extends a load.
  - tlast_err clears only on Reset.
- Read side:
  - rd_valid = bank_full[read_bank] (registered flags).
  - rd_next while rd_valid=0: ignored.
  - rd_next with rd_valid=1 and rd_ptr!=chsz[read_bank]-1: rd_ptr++.
  - rd_next with rd_valid=1 and rd_ptr==chsz[read_bank]-1: rd_ptr<=0, bank_full[read_bank]<=0, read_bank toggles, last_channel=1 next cycle.
  - rd_addr is registered and updates the cycle after rd_next.
- Simultaneous events:
  - A load completing and a read freeing a bank always target different banks, so both flag updates apply in the same cycle.
  - With both banks full, load_req stalls until a read frees a bank. The load may then start the cycle after bank_full clears.
- Each bank uses its own latched chsz, so consecutive kernels may have different channel_size.
- channel_size=0 is illegal and its behaviour is undefined; benches must not drive it.

Test Plan:
- Reset, channel_size=4, load_req, stream 4 words with tlast on word 4 -> writes to addresses 0..3 one cycle after each handshake; done_loading pulse; bank_full=01; rd_valid=1; tlast_err=0.
- Same load with tvalid gapped every other cycle -> exactly 4 writes, no duplicates, done_loading once.
- Ping-pong:
  - Load kernel A (size 3) into bank 0 and kernel B (size 5) into bank 1.
  - Third load_req held: tready stays 0 while bank_full=11.
  - Issue 3 rd_next -> rd_addr 0,1,2; last_channel after the 3rd; bank_full=10.
  - Held load starts into bank 0; rd_addr continues 512..516 for B.
- tlast asserted on word 2 of 4 -> tlast_err=1, load still completes after 4 words; tlast_err stays 1 across the next clean load.
- rd_next with bank_full=00 -> rd_addr unchanged, no last_channel.
- Reset=0 after 2 of 4 words -> all outputs 0; a fresh load_req writes from bank 0 address 0.
